// File: rtl/fp_div_result_buffer_pkg.sv
// fp_div_result_buffer_pkg: shared widths and result record for the FP divider result buffer
package fp_div_result_buffer_pkg;
  localparam int FP_WIDTH = 32;
  localparam int NUSFLAGS_DIV = 5;
  localparam int DIV_TAG_WIDTH = 5;
  localparam int DEFAULT_DIV_RESULT_DEPTH = 4;
  typedef struct packed {
    logic [FP_WIDTH-1:0]      res;
    logic [DIV_TAG_WIDTH-1:0] tag;
    logic [NUSFLAGS_DIV-1:0]  status;
  } fp_div_result_t;
endpackage

// File: rtl/fp_div_result_fifo.sv
// fp_div_result_fifo: DEPTH x WIDTH first-word fall-through FIFO with occupancy count
//   push_i/data_i write (accepted when not full or popping), pop_i/data_o read head,
//   count_o occupancy, full_o/empty_o flags; data_o is 0 when empty.
module fp_div_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic wr_en, rd_en;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full_o = count_o == CW'(DEPTH);
  assign empty_o = count_o == '0;
  assign wr_en = push_i & (~full_o | pop_i);
  assign rd_en = pop_i & ~empty_o;
  assign data_o = empty_o ? '0 : mem[rd_ptr];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count_o <= '0;
    end else begin
      if (wr_en) wr_ptr <= nxt(wr_ptr);
      if (rd_en) rd_ptr <= nxt(rd_ptr);
      count_o <= count_o + CW'(wr_en) - CW'(rd_en);
    end
  end
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= data_i;
  end
endmodule

// File: rtl/fp_div_result_buffer.sv
// fp_div_result_buffer: buffers FP divider results and issues credits so no result is lost
//   IssueReq_i/IssueGnt_o upstream credit, Div* divider result inputs, Out*/OutReady_i
//   consumer handshake, Empty_o idle indication, Error_o sticky protocol error.
//   Define FP_DIV_RESULT_BYPASS_EN to forward a result straight to Out* when the FIFO is empty.
module fp_div_result_buffer
  import fp_div_result_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DIV_RESULT_DEPTH,
  parameter int TAG_WIDTH = DIV_TAG_WIDTH,
  parameter int STAT_WIDTH = NUSFLAGS_DIV,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int W = FP_WIDTH + TAG_WIDTH + STAT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  IssueReq_i,
  output logic                  IssueGnt_o,
  input  logic                  DivValid_i,
  input  logic [FP_WIDTH-1:0]   DivRes_i,
  input  logic [TAG_WIDTH-1:0]  DivTag_i,
  input  logic [STAT_WIDTH-1:0] DivStatus_i,
  output logic                  OutValid_o,
  input  logic                  OutReady_i,
  output logic [FP_WIDTH-1:0]   OutRes_o,
  output logic [TAG_WIDTH-1:0]  OutTag_o,
  output logic [STAT_WIDTH-1:0] OutStatus_o,
  output logic                  Empty_o,
  output logic                  Error_o
);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  logic [CW-1:0] count, inflight;
  logic [W-1:0] head;
  logic full, empty, push, pop, iss, err_q;
  // Credits cover both buffered and in-flight results, so every started division has a slot.
  assign IssueGnt_o = rst_ni & IssueReq_i & (({1'b0, count} + {1'b0, inflight}) < DEPTH_W);
  assign iss = IssueReq_i & IssueGnt_o;
  assign pop = ~empty & OutReady_i;
  assign Empty_o = empty & (inflight == '0);
  assign Error_o = err_q;
`ifdef FP_DIV_RESULT_BYPASS_EN
  logic div_v, bypass;
  assign div_v = DivValid_i & rst_ni;
  assign bypass = empty & div_v & OutReady_i;
  assign push = DivValid_i & ~bypass;
  assign OutValid_o = ~empty | div_v;
  assign {OutRes_o, OutTag_o, OutStatus_o} = ~empty ? head : div_v ? {DivRes_i, DivTag_i, DivStatus_i} : '0;
`else
  assign push = DivValid_i;
  assign OutValid_o = ~empty;
  assign {OutRes_o, OutTag_o, OutStatus_o} = head;
`endif
  fp_div_result_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({DivRes_i, DivTag_i, DivStatus_i}),
    .data_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
  // An unexpected result (nothing in flight) leaves inflight at zero instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight <= '0;
      err_q <= 1'b0;
    end else begin
      inflight <= inflight + CW'(iss) - CW'(DivValid_i & (inflight != '0));
      if (DivValid_i & ((full & ~pop) | (inflight == '0))) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fp_div_result_buffer.sv
// tb_fp_div_result_buffer: randomized and directed checks against a queue-based reference model
module tb_fp_div_result_buffer;
  import fp_div_result_buffer_pkg::*;
  localparam int DEPTH = DEFAULT_DIV_RESULT_DEPTH;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic IssueReq_i = 1'b0, IssueGnt_o, DivValid_i = 1'b0, OutValid_o, OutReady_i = 1'b0;
  logic [FP_WIDTH-1:0] DivRes_i = '0, OutRes_o;
  logic [DIV_TAG_WIDTH-1:0] DivTag_i = '0, OutTag_o;
  logic [NUSFLAGS_DIV-1:0] DivStatus_i = '0, OutStatus_o;
  logic Empty_o, Error_o;
  int n_vec = 0, n_err = 0, tg = 0, gnt_seen = 0;
  fp_div_result_t q[$];
  int m_infl = 0;
  bit m_err = 0;

  fp_div_result_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(DIV_TAG_WIDTH), .STAT_WIDTH(NUSFLAGS_DIV)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .IssueReq_i(IssueReq_i), .IssueGnt_o(IssueGnt_o),
    .DivValid_i(DivValid_i), .DivRes_i(DivRes_i), .DivTag_i(DivTag_i), .DivStatus_i(DivStatus_i),
    .OutValid_o(OutValid_o), .OutReady_i(OutReady_i), .OutRes_o(OutRes_o), .OutTag_o(OutTag_o),
    .OutStatus_o(OutStatus_o), .Empty_o(Empty_o), .Error_o(Error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic fp_div_result_t mk(input int t);
    fp_div_result_t r;
    r.res = $urandom;
    r.tag = DIV_TAG_WIDTH'(t);
    r.status = NUSFLAGS_DIV'($urandom);
    return r;
  endfunction

  // One clock cycle: drive, compare against the model mid-cycle, then advance the model at the edge.
  task automatic cycle(input bit req, input bit dv, input bit rdy, input fp_div_result_t d);
    bit gnt, ov, pop, full;
    fp_div_result_t hd;
    IssueReq_i = req;
    DivValid_i = dv;
    {DivRes_i, DivTag_i, DivStatus_i} = d;
    OutReady_i = rdy;
    gnt = req && (q.size() + m_infl < DEPTH);
    ov = q.size() != 0;
    hd = ov ? q[0] : '0;
    @(negedge clk_i);
    if (IssueGnt_o === 1'b1) gnt_seen++;
    chk("gnt", IssueGnt_o, gnt);
    chk("valid", OutValid_o, ov);
    chk("res", OutRes_o, hd.res);
    chk("tag", OutTag_o, hd.tag);
    chk("status", OutStatus_o, hd.status);
    chk("empty", Empty_o, q.size() == 0 && m_infl == 0);
    chk("error", Error_o, m_err);
    @(posedge clk_i);
    pop = ov && rdy;
    full = q.size() == DEPTH;
    if (dv && m_infl == 0) m_err = 1;
    if (pop) void'(q.pop_front());
    if (dv) begin
      if (full && !pop) m_err = 1;
      else q.push_back(d);
    end
    m_infl = m_infl + int'(gnt) - int'(dv && m_infl > 0);
    #1;
  endtask

  task automatic do_reset();
    IssueReq_i = 1'b1;
    DivValid_i = 1'b1;
    OutReady_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    chk("rst_valid", OutValid_o, 1'b0);
    chk("rst_empty", Empty_o, 1'b1);
    chk("rst_error", Error_o, 1'b0);
    chk("rst_gnt", IssueGnt_o, 1'b0);
    chk("rst_res", OutRes_o, '0);
    q.delete();
    m_infl = 0;
    m_err = 0;
    IssueReq_i = 1'b0;
    DivValid_i = 1'b0;
    OutReady_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    fp_div_result_t r;
    do_reset();
    // single issue, result four cycles later, visible the cycle after
    cycle(1, 0, 1, '0);
    repeat (3) cycle(0, 0, 1, '0);
    r = mk(3);
    r.res = 32'h3F800000;
    cycle(0, 1, 1, r);
    chk("t1_valid", OutValid_o, 1'b1);
    chk("t1_res", OutRes_o, 32'h3F800000);
    chk("t1_tag", OutTag_o, 5'd3);
    cycle(0, 0, 1, '0);
    chk("t1_empty", Empty_o, 1'b1);
    // credit exhaustion with a stalled consumer
    gnt_seen = 0;
    repeat (6) cycle(1, 0, 0, '0);
    chk("grants", gnt_seen, DEPTH);
    for (int i = 0; i < DEPTH; i++) cycle(1, 1, 0, mk(i));
    cycle(1, 0, 1, '0);
    cycle(1, 0, 0, '0);
    cycle(0, 1, 0, mk(4));
    // full with simultaneous pop and a result (nothing in flight so it also flags)
    cycle(0, 1, 1, mk(5));
    repeat (6) cycle(0, 0, 1, '0);
    chk("sticky", Error_o, 1'b1);
    // overflow drop
    do_reset();
    repeat (DEPTH) cycle(1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, mk(i));
    cycle(0, 1, 0, mk(9));
    chk("ovf_err", Error_o, 1'b1);
    repeat (6) cycle(0, 0, 1, '0);
    // unexpected result while nothing in flight
    do_reset();
    cycle(0, 1, 0, mk(7));
    chk("unexp_err", Error_o, 1'b1);
    repeat (2) cycle(0, 0, 1, '0);
    // back-to-back with toggling ready
    do_reset();
    tg = 0;
    for (int i = 0; i < 200 && tg < 16; i++) begin
      bit dv;
      dv = m_infl > 0;
      cycle(1, dv, i[0] == 1'b0, mk(tg));
      if (dv) tg++;
    end
    chk("t16_count", tg, 16);
    repeat (8) cycle(0, 0, 1, '0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit dv;
      dv = m_infl > 0 && $urandom_range(1) == 1;
      cycle($urandom_range(1) == 1, dv, $urandom_range(2) != 0, mk(tg));
      if (dv) tg++;
    end
    // asynchronous reset with two buffered and one in flight
    do_reset();
    repeat (3) cycle(1, 0, 0, '0);
    repeat (2) cycle(0, 1, 0, mk(tg));
    chk("pre_rst_valid", OutValid_o, 1'b1);
    do_reset();
    cycle(0, 1, 1, mk(11));
    cycle(0, 0, 1, '0);
    chk("post_rst_err", Error_o, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
